mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-port nvm_mem between NUM_REQ requesters (CPU fetch/data port, program loader/debug port).
- Round-robin arbitration with an optional bus lock for atomic multi-access sequences.
- Routes tagged read responses back to the issuing requester.
- Sits at chip level between requesters and the memory macro.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- NUM_REQ, 2, number of requesters (2..8)
- MEM_RD_LAT, 1, cycles from memory address sample to valid mem_rd (1..4)
- LOCK_TIMEOUT, 16, idle-owner cycles before a held lock is forcibly released (>=2)

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep grant after this access
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- rsp_valid  out  NUM_REQ  read data valid for requester i
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wd  out  DATA_WIDTH  memory write data
- mem_rd  in  DATA_WIDTH  memory read data
- busy  out  1  lock held or read in flight
- lock_err  out  1  one-cycle pulse on lock timeout

Behaviour:
- Handshake: an access is accepted when req_valid[i] and req_ready[i] are both high. req_valid must not depend on req_ready. At most one access is accepted per cycle.
- Accepted requester i holds its valid and payload until ready.
- Memory drive is combinational from the winner in the accept cycle:
  - mem_addr and mem_wd come from the winner.
  - mem_we = accept & req_we[win].
  - With no accept: mem_we = 0, mem_addr and mem_wd = 0.
- Writes complete at acceptance and produce no response.
- Reads: rsp_valid[id] pulses exactly MEM_RD_LAT cycles after the accept edge, with rsp_rdata = mem_rd in that cycle. rsp_rdata = 0 when no rsp_valid is high.
- Reads accept back-to-back every cycle. Tag pipeline depth is MEM_RD_LAT, entries {valid, id}, so responses stay in issue order.
- FSM states:
  - ARB:
    - Round-robin: priority starts at (last_grant+1) mod NUM_REQ; the first valid requester wins.
    - last_grant updates on every accept.
    - Accept with req_lock=1 moves to LOCK with owner = id.
  - LOCK:
    - Only the owner may be granted. All other ready signals stay 0.
    - Owner accept with req_lock=0 returns to ARB; last_grant = owner.
    - Idle counter clears on every owner accept and increments each cycle the owner is not valid.
    - Counter reaching LOCK_TIMEOUT: pulse lock_err, return to ARB. Arbitration resumes the next cycle.
- Lock may begin with either a read or a write. Locked reads still return responses normally.
- busy = (state == LOCK) | any tag-pipeline entry valid.
- Reset (sync, any time, including mid-read):
  - state = ARB, last_grant = NUM_REQ-1 so requester 0 wins first, tag pipeline cleared.
  - All outputs 0; no rsp_valid for accesses accepted before reset.
- NUM_REQ=1: arbitration degenerates to pass-through. Lock and timeout still apply.

Decomposition:
- Add to pkg_cpu_typedefs:
  - arb_state_t enum {ARB_IDLE_RR, ARB_LOCKED}
  - rsp_tag_t struct {logic vld; logic [$clog2(NUM_REQ)-1:0] id}, parameterised via localparam width constant ARB_ID_W.
- One sub-module: mem_arb_rr_picker. Combinational rotate-priority picker with inputs req vector and last_grant, outputs one-hot grant and encoded id.
- FSM, lock counter and tag pipeline stay in the top.

Test Plan:
- Reset, then req0 read addr 0x10 (mem holds 0xDEADBEEF), MEM_RD_LAT=1 -> req_ready[0]=1 same cycle, rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF next cycle, mem_we=0 throughout.
- Both requesters continuously valid for reads, 6 accesses -> grant order 0,1,0,1,0,1; each rsp_valid matches its issuer; one accept per cycle.
- req1 writes 0x100, 0x104 (lock=1) then 0x108 (lock=0) while req0 valid -> req_ready[0]=0 for those 3 cycles, req0 granted on cycle 4, mem_we=1 on cycles 1-3.
- req1 locks with one read then drops valid, req0 valid -> lock_err pulses on idle cycle 16, req0 granted on the following cycle, busy low after the read response.
- MEM_RD_LAT=3, 4 alternating back-to-back reads -> rsp_valid pattern 0,1,0,1 starting 3 cycles after the first accept, data correct per address.
- Read accepted, sys_rst asserted the next cycle for 1 cycle -> no rsp_valid afterwards, busy=0, first post-reset grant goes to req0.

Source files
------------

// File: rtl/pkg_cpu_typedefs.sv
// Shared types for the memory bus arbiter: FSM state encoding and read-response tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// ARB_ID_W is sized for the largest supported requester count (8), so one tag
// layout serves every NUM_REQ the arbiter can be built with, including NUM_REQ=1.
package pkg_cpu_typedefs;

    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_ID_W    = $clog2(ARB_MAX_REQ);

    typedef enum logic [0:0] {
        ARB_IDLE_RR = 1'b0,
        ARB_LOCKED  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                vld;
        logic [ARB_ID_W-1:0] id;
    } rsp_tag_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Rotating-priority picker: first set bit of req at or after (last_grant+1) mod NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; grant is zero when req is zero.
// Ports: req (eligible requesters), last_grant (previous winner id),
//        grant (one-hot winner), grant_id (encoded winner, 0 when no grant).
module mem_arb_rr_picker
    import pkg_cpu_typedefs::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ARB_ID_W-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ARB_ID_W-1:0] grant_id
);

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // last_grant is always < NUM_REQ, so one conditional subtract wraps it
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            // compare against every constant position so req is only ever
            // indexed with an elaboration-time constant
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    grant_id = ARB_ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters, with bus lock.
// Latency: memory drive is combinational in the accept cycle; read data returns MEM_RD_LAT cycles later.
// Backpressure: valid/ready per requester, at most one accept per cycle; non-owners stalled while locked.
// Ports: sys_clk/sys_rst (sync, active-high); req_* per-requester request channel (flattened
//        addr/wdata); rsp_valid/rsp_rdata tagged read return; mem_* memory macro side;
//        busy = lock held or read in flight; lock_err = one-cycle pulse on lock timeout.
module mem_bus_arbiter
    import pkg_cpu_typedefs::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 2,
    parameter int MEM_RD_LAT   = 1,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wd,
    input  logic [DATA_WIDTH-1:0]         mem_rd,
    output logic                          busy,
    output logic                          lock_err
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t          state;
    logic [ARB_ID_W-1:0] last_grant;
    logic [ARB_ID_W-1:0] owner;
    logic [CNT_W-1:0]    idle_cnt;
    rsp_tag_t            tag_pipe [MEM_RD_LAT];
    rsp_tag_t            tag_out;

    logic [NUM_REQ-1:0]    own_mask;
    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    grant;
    logic [ARB_ID_W-1:0]   win_id;
    logic                  accept;
    logic                  win_we;
    logic                  win_lock;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wd;
    logic                  owner_vld;
    logic                  timeout;
    logic                  tags_busy;

    always_comb begin
        own_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            own_mask[i] = (owner == ARB_ID_W'(i));
        end
    end

    assign owner_vld = |(req_valid & own_mask);

    // While locked only the owner is eligible; the picker then trivially selects it.
    assign elig = (state == ARB_LOCKED) ? (req_valid & own_mask) : req_valid;

    mem_arb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (elig),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (win_id)
    );

    // grant is one-hot, so OR-ing the masked fields is a plain mux
    always_comb begin
        win_we   = 1'b0;
        win_lock = 1'b0;
        win_addr = '0;
        win_wd   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_we   = req_we[i];
                win_lock = req_lock[i];
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wd   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs are forced quiet during reset even though requesters may still be driving.
    assign accept    = (|grant) & ~sys_rst;
    assign req_ready = sys_rst ? '0 : grant;
    assign mem_we    = accept & win_we;
    assign mem_addr  = accept ? win_addr : '0;
    assign mem_wd    = accept ? win_wd : '0;

    // Fires on the LOCK_TIMEOUT-th consecutive idle owner cycle.
    assign timeout  = (state == ARB_LOCKED) && !owner_vld &&
                      (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign lock_err = timeout & ~sys_rst;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ARB_IDLE_RR;
            last_grant <= ARB_ID_W'(NUM_REQ - 1);
            owner      <= '0;
            idle_cnt   <= '0;
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            if (accept) begin
                last_grant <= win_id;
            end

            case (state)
                ARB_IDLE_RR: begin
                    if (accept && win_lock) begin
                        state    <= ARB_LOCKED;
                        owner    <= win_id;
                        idle_cnt <= '0;
                    end
                end
                ARB_LOCKED: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (!win_lock) begin
                            state <= ARB_IDLE_RR;
                        end
                    end else if (timeout) begin
                        state    <= ARB_IDLE_RR;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE_RR;
            endcase

            // One entry per accept cycle keeps responses in issue order.
            tag_pipe[0].vld <= accept & ~win_we;
            tag_pipe[0].id  <= win_id;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[MEM_RD_LAT-1];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = ~sys_rst & tag_out.vld & (tag_out.id == ARB_ID_W'(i));
        end
    end

    assign rsp_rdata = (~sys_rst & tag_out.vld) ? mem_rd : '0;

    always_comb begin
        tags_busy = 1'b0;
        for (int i = 0; i < MEM_RD_LAT; i++) begin
            tags_busy = tags_busy | tag_pipe[i].vld;
        end
    end

    assign busy = ~sys_rst & ((state == ARB_LOCKED) | tags_busy);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (MEM_RD_LAT=1 and 3) share one directed stimulus stream.
// Latency: request side checked in the drive cycle; responses scoreboarded against issue cycle + latency.
// Backpressure: expected req_ready per cycle is hand-computed in the vectors.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        sys_rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  req_lock;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic [1:0]  o_ready     [2];
    logic [1:0]  o_rsp_valid [2];
    logic [31:0] o_rsp_rdata [2];
    logic        o_mem_we    [2];
    logic [31:0] o_mem_addr  [2];
    logic [31:0] o_mem_wd    [2];
    logic [31:0] mem_rd      [2];
    logic        o_busy      [2];
    logic        o_lock_err  [2];
    logic [31:0] rd_p1;
    logic [31:0] rd_p2;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q [2][$];
    int   cyc;
    int   n_cmp;
    int   n_fail;

    mem_bus_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(2), .MEM_RD_LAT(1), .LOCK_TIMEOUT(16)
    ) dut_l1 (
        .sys_clk(clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(o_ready[0]),
        .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(o_rsp_valid[0]), .rsp_rdata(o_rsp_rdata[0]), .mem_we(o_mem_we[0]),
        .mem_addr(o_mem_addr[0]), .mem_wd(o_mem_wd[0]), .mem_rd(mem_rd[0]),
        .busy(o_busy[0]), .lock_err(o_lock_err[0])
    );

    mem_bus_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(2), .MEM_RD_LAT(3), .LOCK_TIMEOUT(16)
    ) dut_l3 (
        .sys_clk(clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(o_ready[1]),
        .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(o_rsp_valid[1]), .rsp_rdata(o_rsp_rdata[1]), .mem_we(o_mem_we[1]),
        .mem_addr(o_mem_addr[1]), .mem_wd(o_mem_wd[1]), .mem_rd(mem_rd[1]),
        .busy(o_busy[1]), .lock_err(o_lock_err[1])
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: address sampled at the edge, data valid MEM_RD_LAT cycles later
    always @(posedge clk) begin
        mem_rd[0] <= data_of(o_mem_addr[0]);
        rd_p1     <= data_of(o_mem_addr[1]);
        rd_p2     <= rd_p1;
        mem_rd[1] <= rd_p2;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // response monitor
    always @(negedge clk) begin
        if (!sys_rst) begin
            for (int k = 0; k < 2; k++) begin
                exp_t        e;
                logic [1:0]  ev;
                if (q[k].size() > 0 && q[k][0].due < cyc) begin
                    e = q[k].pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_missing lat%0d: id %0d due cyc %0d, none by cyc %0d",
                             lat(k), e.id, e.due, cyc);
                end
                if (o_rsp_valid[k] != 2'b00) begin
                    if (q[k].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rsp_unexpected lat%0d: rsp_valid %b with nothing outstanding",
                                 lat(k), o_rsp_valid[k]);
                    end else begin
                        e = q[k].pop_front();
                        ev = 2'b00;
                        ev[e.id] = 1'b1;
                        chk($sformatf("rsp_valid lat%0d", lat(k)), 64'(o_rsp_valid[k]), 64'(ev));
                        chk($sformatf("rsp_rdata lat%0d", lat(k)), 64'(o_rsp_rdata[k]), 64'(e.data));
                        chk($sformatf("rsp_cycle lat%0d", lat(k)), 64'(cyc), 64'(e.due));
                    end
                end else begin
                    chk($sformatf("rdata_idle lat%0d", lat(k)), 64'(o_rsp_rdata[k]), 64'd0);
                end
            end
        end
    end

    // one cycle of stimulus with the hand-computed expected grant and lock_err
    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] exp_rdy, input logic exp_lerr);
        logic        acc;
        int          win;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        exp_t        e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {a1 ^ 32'hCAFE0000, a0 ^ 32'hCAFE0000};
        #3;
        acc    = |exp_rdy;
        win    = exp_rdy[1] ? 1 : 0;
        e_we   = acc & we[win];
        e_addr = acc ? (win == 1 ? a1 : a0) : 32'h0;
        e_wd   = acc ? (e_addr ^ 32'hCAFE0000) : 32'h0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req_ready lat%0d", lat(k)), 64'(o_ready[k]), 64'(exp_rdy));
            chk($sformatf("mem_we lat%0d", lat(k)), 64'(o_mem_we[k]), 64'(e_we));
            chk($sformatf("mem_addr lat%0d", lat(k)), 64'(o_mem_addr[k]), 64'(e_addr));
            chk($sformatf("mem_wd lat%0d", lat(k)), 64'(o_mem_wd[k]), 64'(e_wd));
            chk($sformatf("lock_err lat%0d", lat(k)), 64'(o_lock_err[k]), 64'(exp_lerr));
            if (acc && !we[win]) begin
                e.id   = win;
                e.data = data_of(e_addr);
                e.due  = cyc + lat(k);
                q[k].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        end
    endtask

    task automatic chk_busy(input logic e0, input logic e1);
        chk("busy lat1", 64'(o_busy[0]), 64'(e0));
        chk("busy lat3", 64'(o_busy[1]), 64'(e1));
    endtask

    // one reset cycle with both requesters valid; all outputs must stay quiet
    task automatic rst_cycle();
        @(posedge clk);
        #1;
        sys_rst   = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_lock  = 2'b00;
        req_addr  = {32'h44, 32'h40};
        q[0].delete();
        q[1].delete();
        #3;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ctl lat%0d", lat(k)),
                64'({o_ready[k], o_rsp_valid[k], o_mem_we[k], o_busy[k], o_lock_err[k]}), 64'd0);
            chk($sformatf("rst_data lat%0d", lat(k)), {o_rsp_rdata[k], o_mem_addr[k]}, 64'd0);
            chk($sformatf("rst_wd lat%0d", lat(k)), 64'(o_mem_wd[k]), 64'd0);
        end
        @(posedge clk);
        #1;
        sys_rst   = 1'b0;
        req_valid = 2'b00;
    endtask

    initial begin
        clk       = 1'b0;
        sys_rst   = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_lock  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        cyc       = 0;
        n_cmp     = 0;
        n_fail    = 0;

        rst_cycle();
        rst_cycle();

        // single read of 0xDEADBEEF from requester 0
        step(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 2'b01, 1'b0);
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        chk_busy(1'b1, 1'b1);
        idle(4);
        chk_busy(1'b0, 1'b0);
        rst_cycle();

        // both requesters streaming reads: strict alternation starting at 0
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b00, 2'b00, 32'h200 + 32'(4 * ((i + 1) / 2)), 32'h300 + 32'(4 * (i / 2)),
                 (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        end
        idle(4);

        // locked write burst from requester 1 holds off requester 0
        step(2'b01, 2'b00, 2'b00, 32'h600, 32'h0, 2'b01, 1'b0);
        step(2'b11, 2'b10, 2'b10, 32'h610, 32'h100, 2'b10, 1'b0);
        step(2'b11, 2'b10, 2'b10, 32'h610, 32'h104, 2'b10, 1'b0);
        chk_busy(1'b1, 1'b1);
        step(2'b11, 2'b10, 2'b00, 32'h610, 32'h108, 2'b10, 1'b0);
        step(2'b01, 2'b00, 2'b00, 32'h610, 32'h0, 2'b01, 1'b0);

        // lock taken with a read then abandoned: timeout on the 16th idle cycle
        step(2'b11, 2'b00, 2'b10, 32'h700, 32'h710, 2'b10, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(2'b01, 2'b00, 2'b00, 32'h720, 32'h0, 2'b00, (i == 16) ? 1'b1 : 1'b0);
            if (i == 8) chk_busy(1'b1, 1'b1);
        end
        step(2'b01, 2'b00, 2'b00, 32'h720, 32'h0, 2'b01, 1'b0);
        idle(5);
        chk_busy(1'b0, 1'b0);

        // reset right after a read accept drops its response and restarts priority at 0
        step(2'b01, 2'b00, 2'b00, 32'h800, 32'h0, 2'b01, 1'b0);
        rst_cycle();
        step(2'b11, 2'b00, 2'b00, 32'h810, 32'h820, 2'b01, 1'b0);
        chk_busy(1'b0, 1'b0);
        idle(5);
        chk_busy(1'b0, 1'b0);

        chk("queue_empty lat1", 64'(q[0].size()), 64'd0);
        chk("queue_empty lat3", 64'(q[1].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
